// File: rtl/retospect_lif_neuron.sv
// Leaky integrate-and-fire neuron with a serially shifted configuration word.
// The configuration register doubles as a shift-register stage so neurons can
// be daisy-chained on one bitstream. Weights are signed. The potential is
// unsigned and clamped. A decay strobe selected from the clockbus halves the
// potential, and an optional refractory period follows each spike.
module retospect_lif_neuron #(
  parameter int NUM_DENDRITES = 4,
  parameter int W_WIDTH       = 4,
  parameter int POT_WIDTH     = 8,
  parameter int REFRAC_WIDTH  = 3,
  parameter int DSEL_WIDTH    = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       reset_nn,
  input  logic                       config_en,
  input  logic                       bs_in,
  output logic                       bs_out,
  input  logic [2**DSEL_WIDTH-1:0]   clockbus,
  input  logic [NUM_DENDRITES-1:0]   dendrite,
  output logic                       axon
);

  localparam int CFG_BITS = NUM_DENDRITES*W_WIDTH + POT_WIDTH + REFRAC_WIDTH + DSEL_WIDTH;
  localparam int SUM_W    = W_WIDTH + $clog2(NUM_DENDRITES) + 1;
  // Wide enough for any unsigned potential plus any signed dendrite sum.
  localparam int NXT_W    = POT_WIDTH + SUM_W;
  localparam logic signed [NXT_W-1:0] POT_MAX = {{(NXT_W-POT_WIDTH){1'b0}}, {POT_WIDTH{1'b1}}};

  typedef enum logic [1:0] {INTEG, FIRE, REFRACT} state_t;

  logic [CFG_BITS-1:0]          cfg;
  logic [POT_WIDTH-1:0]         potential;
  logic [REFRAC_WIDTH-1:0]      counter;
  state_t                       state;

  logic [POT_WIDTH-1:0]         thresh;
  logic [REFRAC_WIDTH-1:0]      refrac;
  logic [DSEL_WIDTH-1:0]        dsel;
  logic signed [W_WIDTH-1:0]    w [NUM_DENDRITES];
  logic signed [SUM_W-1:0]      sum;
  logic [POT_WIDTH-1:0]         decayed;
  logic signed [NXT_W-1:0]      nxt_raw;
  logic [POT_WIDTH-1:0]         nxt;
  logic                         fire;

  // Clamp the raw next potential into the unsigned potential range.
  function automatic logic [POT_WIDTH-1:0] sat_pot(input logic signed [NXT_W-1:0] v);
    if (v < 0)
      return '0;
    else if (v > POT_MAX)
      return {POT_WIDTH{1'b1}};
    else
      return v[POT_WIDTH-1:0];
  endfunction

  // Field decode: w[0] sits at the MSB end, dsel at the LSB end.
  assign dsel   = cfg[DSEL_WIDTH-1:0];
  assign refrac = cfg[DSEL_WIDTH +: REFRAC_WIDTH];
  assign thresh = cfg[DSEL_WIDTH+REFRAC_WIDTH +: POT_WIDTH];

  for (genvar g = 0; g < NUM_DENDRITES; g++) begin : g_w
    assign w[g] = cfg[CFG_BITS-1-g*W_WIDTH -: W_WIDTH];
  end

  // The LSB of the configuration word is the next bit handed down the chain.
  assign bs_out = cfg[0];

  // Signed sum of the weights of all active dendrites.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_DENDRITES; i++)
      if (dendrite[i])
        sum = sum + SUM_W'(w[i]);
  end

  // Decay, integrate, saturate and compare against the threshold.
  always_comb begin
    decayed = clockbus[dsel] ? (potential >> 1) : potential;
    nxt_raw = $signed({{(NXT_W-POT_WIDTH){1'b0}}, decayed}) + NXT_W'(sum);
    nxt     = sat_pot(nxt_raw);
    fire    = (nxt >= thresh);
  end

  // Mode arbitration and neuron FSM; axon is registered and high only in FIRE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg       <= '0;
      potential <= '0;
      counter   <= '0;
      axon      <= 1'b0;
      state     <= INTEG;
    end else if (reset_nn) begin
      potential <= '0;
      counter   <= '0;
      axon      <= 1'b0;
      state     <= INTEG;
    end else if (config_en) begin
      cfg     <= {bs_in, cfg[CFG_BITS-1:1]};
      counter <= '0;
      axon    <= 1'b0;
      state   <= INTEG;
    end else begin
      case (state)
        INTEG: begin
          if (fire) begin
            potential <= '0;
            axon      <= 1'b1;
            state     <= FIRE;
          end else begin
            potential <= nxt;
            axon      <= 1'b0;
          end
        end
        FIRE: begin
          axon <= 1'b0;
          if (refrac == '0) begin
            state <= INTEG;
          end else begin
            counter <= refrac;
            state   <= REFRACT;
          end
        end
        REFRACT: begin
          potential <= '0;
          axon      <= 1'b0;
          if (counter <= REFRAC_WIDTH'(1)) begin
            counter <= '0;
            state   <= INTEG;
          end else begin
            counter <= counter - 1'b1;
          end
        end
        default: begin
          axon  <= 1'b0;
          state <= INTEG;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_retospect_lif_neuron.sv
// Directed testbench for retospect_lif_neuron at default parameters.
module tb_retospect_lif_neuron;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       reset_nn;
  logic       config_en;
  logic       bs_in;
  logic       bs_out;
  logic [7:0] clockbus;
  logic [3:0] dendrite;
  logic       axon;

  int checks   = 0;
  int failures = 0;

  retospect_lif_neuron dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .reset_nn  (reset_nn),
    .config_en (config_en),
    .bs_in     (bs_in),
    .bs_out    (bs_out),
    .clockbus  (clockbus),
    .dendrite  (dendrite),
    .axon      (axon)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [29:0] mk(input logic [3:0] w0, input logic [3:0] w1,
                                     input logic [3:0] w2, input logic [3:0] w3,
                                     input logic [7:0] th, input logic [2:0] rf,
                                     input logic [2:0] ds);
    return {w0, w1, w2, w3, th, rf, ds};
  endfunction

  task automatic load_cfg(input logic [29:0] v);
    config_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      bs_in = v[i];
      step();
    end
    config_en = 1'b0;
    bs_in     = 1'b0;
  endtask

  logic [29:0] pat_a;
  logic [29:0] pat_b;
  logic [29:0] cfg_v;
  logic [7:0]  pot_tab [5];
  logic        axn_tab [5];
  logic [7:0]  dec_tab [5];

  initial begin
    rst_n     = 1'b0;
    reset_nn  = 1'b0;
    config_en = 1'b0;
    bs_in     = 1'b0;
    dendrite  = 4'b0000;
    clockbus  = 8'b0000_0010;
    pot_tab   = '{8'd3, 8'd6, 8'd9, 8'd0, 8'd0};
    axn_tab   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    dec_tab   = '{8'd4, 8'd2, 8'd1, 8'd0, 8'd0};

    // Reset state
    #12;
    chk("rst_axon", axon, 0);
    chk("rst_bs_out", bs_out, 0);
    chk("rst_potential", dut.potential, 0);
    rst_n = 1'b1;

    // All-zero config: thresh 0 fires on every INTEG cycle
    step(); chk("zero_cfg_fire1", axon, 1);
    step(); chk("zero_cfg_gap", axon, 0);
    step(); chk("zero_cfg_fire2", axon, 1);

    // Configuration chain
    pat_a = mk(4'h5, 4'hA, 4'h3, 4'hC, 8'h96, 3'd5, 3'd3);
    pat_b = mk(4'h9, 4'h1, 4'hE, 4'h6, 8'h4B, 3'd2, 3'd6);
    load_cfg(pat_a);
    chk("chain_cfg_a", dut.cfg, pat_a);
    chk("chain_thresh_a", dut.thresh, 8'h96);
    chk("chain_cfg_axon", axon, 0);
    config_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      chk("chain_replay", bs_out, pat_a[i]);
      bs_in = pat_b[i];
      step();
    end
    config_en = 1'b0;
    chk("chain_cfg_b", dut.cfg, pat_b);

    // Integrate and fire, two full periods
    load_cfg(mk(4'd3, 4'd0, 4'd0, 4'd0, 8'd10, 3'd0, 3'd0));
    dendrite = 4'b0001;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 5; k++) begin
        step();
        chk("intfire_pot", dut.potential, pot_tab[k]);
        chk("intfire_axon", axon, axn_tab[k]);
      end
    end
    dendrite = 4'b0000;

    // Decay: build potential 9, reconfigure to the always-decay strobe
    load_cfg(mk(4'd3, 4'd0, 4'd0, 4'd0, 8'd100, 3'd0, 3'd0));
    dendrite = 4'b0001;
    step(); step(); step();
    dendrite = 4'b0000;
    chk("decay_pre", dut.potential, 9);
    load_cfg(mk(4'd0, 4'd0, 4'd0, 4'd0, 8'd100, 3'd0, 3'd1));
    chk("reconfig_holds_pot", dut.potential, 9);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("decay_pot", dut.potential, dec_tab[k]);
    end

    // Inhibition clamps at zero without firing
    load_cfg(mk(4'd5, 4'h8, 4'd0, 4'd0, 8'd20, 3'd0, 3'd0));
    dendrite = 4'b0001;
    step(); chk("inhib_pre", dut.potential, 5);
    dendrite = 4'b0010;
    step(); chk("inhib_clamp", dut.potential, 0);
    chk("inhib_axon", axon, 0);
    dendrite = 4'b0000;

    // Saturation to 255 reaches thresh 255
    load_cfg(mk(4'd7, 4'd7, 4'd7, 4'd7, 8'd255, 3'd0, 3'd0));
    dendrite = 4'hF;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk("sat_pot", dut.potential, 28 * k);
    end
    chk("sat_no_fire", axon, 0);
    step();
    chk("sat_fire", axon, 1);
    chk("sat_pot_zero", dut.potential, 0);
    dendrite = 4'b0000;
    step();

    // Refractory period of 3 (dsel 3 selects a tied-low strobe, and makes bs_out 1)
    cfg_v = mk(4'd3, 4'd0, 4'd0, 4'd0, 8'd10, 3'd3, 3'd3);
    load_cfg(cfg_v);
    dendrite = 4'b0001;
    step(); step(); step();
    chk("refr_pre_pot", dut.potential, 9);
    step(); chk("refr_fire", axon, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("refr_ignored_pot", dut.potential, 0);
      chk("refr_ignored_axon", axon, 0);
    end
    step(); chk("refr_resume", dut.potential, 3);
    step(); step(); step();
    chk("refr_fire2", axon, 1);
    step();
    // Now in REFRACT: network reset returns to INTEG at once
    reset_nn = 1'b1;
    step();
    reset_nn = 1'b0;
    chk("nn_pot", dut.potential, 0);
    chk("nn_cfg_intact", dut.cfg, cfg_v);
    step(); chk("nn_integ", dut.potential, 3);
    step(); step(); step();
    chk("nn_fire", axon, 1);
    chk("async_pre_bs_out", bs_out, 1);

    // Asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_axon", axon, 0);
    chk("async_bs_out", bs_out, 0);
    chk("async_cfg", dut.cfg, 0);
    rst_n = 1'b1;
    dendrite = 4'b0000;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
